// File: rtl/mux16_rr_arbiter.sv
// 16-channel round-robin arbiter feeding a registered 16:1 bit mux.
// A granted channel streams up to HOLD_MAX samples before the grant moves on.
module mux16_rr_arbiter #(
    parameter int HOLD_MAX = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] req,
    input  logic [15:0] di,
    input  logic        out_ready,
    output logic [15:0] gnt,
    output logic [3:0]  sel,
    output logic        y,
    output logic        out_valid,
    output logic        busy
);

    localparam logic [4:0] HOLD_LIM = 5'(HOLD_MAX);

    typedef enum logic {IDLE, XFER} state_t;

    state_t      state_q, state_d;
    logic [15:0] gnt_q, gnt_d;
    logic [3:0]  sel_q, sel_d;
    logic [3:0]  ptr_q, ptr_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        y_q, y_d;
    logic        valid_q, valid_d;

    logic [15:0] req_rot;
    logic [3:0]  offset;
    logic [3:0]  winner;
    logic        handshake;
    logic        may_continue;

    // req_rot[0] is the channel at ptr, so the lowest set bit is the winner.
    for (genvar gi = 0; gi < 16; gi++) begin : g_rot
        assign req_rot[gi] = req[ptr_q + 4'(gi)];
    end

    always_comb begin
        offset = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (req_rot[i]) begin
                offset = 4'(i);
            end
        end
    end

    assign winner       = ptr_q + offset;
    assign handshake    = valid_q & out_ready;
    assign may_continue = req[sel_q] && (({1'b0, cnt_q} + 5'd1) < HOLD_LIM);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                if (req != 16'h0000) begin
                    gnt_d   = 16'h0001 << winner;
                    sel_d   = winner;
                    y_d     = di[winner];
                    valid_d = 1'b1;
                    cnt_d   = 4'd0;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (handshake) begin
                    if (may_continue) begin
                        cnt_d = cnt_q + 4'd1;
                        y_d   = di[sel_q];
                    end else begin
                        // sel and y keep their last values across the release.
                        gnt_d   = 16'h0000;
                        valid_d = 1'b0;
                        ptr_d   = sel_q + 4'd1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= 16'h0000;
            sel_q   <= 4'd0;
            ptr_q   <= 4'd0;
            cnt_q   <= 4'd0;
            y_q     <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            valid_q <= valid_d;
        end
    end

    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign y         = y_q;
    assign out_valid = valid_q;
    assign busy      = (state_q == XFER);

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Directed and random checks of mux16_rr_arbiter against a cycle model
// with a sample scoreboard.
module tb_mux16_rr_arbiter;

    localparam int HOLD = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] req = 16'h0000;
    logic [15:0] di  = 16'h0000;
    logic        out_ready = 1'b0;
    logic [15:0] gnt;
    logic [3:0]  sel;
    logic        y;
    logic        out_valid;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic        m_xfer;
    logic [3:0]  m_ptr, m_cnt, m_sel;
    logic        m_y, m_valid;
    logic [15:0] m_gnt;
    logic        sb[$];
    int          waits[16];
    int          max_wait;

    mux16_rr_arbiter #(.HOLD_MAX(HOLD)) dut (
        .clk(clk), .rst(rst), .req(req), .di(di), .out_ready(out_ready),
        .gnt(gnt), .sel(sel), .y(y), .out_valid(out_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_xfer = 1'b0; m_ptr = 4'd0; m_cnt = 4'd0; m_sel = 4'd0;
        m_y = 1'b0; m_valid = 1'b0; m_gnt = 16'h0000;
        sb.delete();
        for (int c = 0; c < 16; c++) waits[c] = 0;
    endtask

    // Called between edges; pulses rst without any clock edge in between.
    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_sel", 32'(sel), 32'h0);
        chk("rst_y", 32'(y), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        model_reset();
        #1 rst = 1'b0;
    endtask

    // One clock edge: advance the model, then compare after the edge.
    task automatic cycle();
        logic       hs;
        logic [3:0] w;
        bit         found;
        hs = m_valid && out_ready;
        if (hs) begin
            chk("sb_depth", 32'(sb.size()), 32'd1);
            if (sb.size() > 0) chk("y_handshake", 32'(y), 32'(sb.pop_front()));
        end
        for (int c = 0; c < 16; c++) if (!req[c]) waits[c] = 0;
        if (!m_xfer) begin
            if (req != 16'h0000) begin
                found = 1'b0;
                w = 4'd0;
                for (int k = 0; k < 16; k++) begin
                    if (!found && req[(int'(m_ptr) + k) % 16]) begin
                        found = 1'b1;
                        w = 4'((int'(m_ptr) + k) % 16);
                    end
                end
                for (int c = 0; c < 16; c++) begin
                    if (req[c] && c != int'(w)) begin
                        waits[c]++;
                        if (waits[c] > max_wait) max_wait = waits[c];
                    end
                end
                waits[w] = 0;
                m_gnt = 16'h0000;
                m_gnt[w] = 1'b1;
                m_sel = w; m_y = di[w]; m_valid = 1'b1; m_cnt = 4'd0; m_xfer = 1'b1;
                sb.push_back(di[w]);
            end
        end else if (hs) begin
            if (req[m_sel] && (int'(m_cnt) + 1 < HOLD)) begin
                m_cnt = m_cnt + 4'd1;
                m_y = di[m_sel];
                sb.push_back(di[m_sel]);
            end else begin
                m_gnt = 16'h0000; m_valid = 1'b0; m_xfer = 1'b0;
                m_ptr = m_sel + 4'd1;
            end
        end
        @(posedge clk);
        #1;
        chk("gnt", 32'(gnt), 32'(m_gnt));
        chk("sel", 32'(sel), 32'(m_sel));
        chk("y", 32'(y), 32'(m_y));
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("busy", 32'(busy), 32'(m_xfer));
        chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
        chk("gnt_iff_busy", 32'(gnt != 16'h0000), 32'(busy));
    endtask

    initial begin
        max_wait = 0;
        model_reset();

        // Scenario 1: first grant after reset
        do_reset();
        req = 16'h0001; di = 16'h0001; out_ready = 1'b1;
        cycle();
        chk("s1_gnt", 32'(gnt), 32'h0001);
        chk("s1_sel", 32'(sel), 32'd0);
        chk("s1_y", 32'(y), 32'd1);
        chk("s1_valid", 32'(out_valid), 32'd1);
        req = 16'h0000;
        cycle();
        chk("s1_release", 32'(out_valid), 32'd0);

        // Scenario 2: 8-sample hold, dead cycle, wrap of ptr
        do_reset();
        req = 16'h8001; out_ready = 1'b1;
        for (int i = 0; i < HOLD; i++) begin
            di = 16'($urandom);
            cycle();
            chk("s2_ch0_gnt", 32'(gnt), 32'h0001);
        end
        cycle();
        chk("s2_dead_gnt", 32'(gnt), 32'h0);
        chk("s2_dead_busy", 32'(busy), 32'h0);
        cycle();
        chk("s2_ch15_gnt", 32'(gnt), 32'h8000);
        chk("s2_ch15_sel", 32'(sel), 32'd15);
        for (int i = 1; i < HOLD; i++) begin
            di = 16'($urandom);
            cycle();
            chk("s2_ch15_hold", 32'(gnt), 32'h8000);
        end
        cycle();
        chk("s2_ch15_rel", 32'(gnt), 32'h0);
        cycle();
        chk("s2_wrap_gnt", 32'(gnt), 32'h0001);
        chk("s2_wrap_sel", 32'(sel), 32'd0);

        // Scenario 3: stall with toggling data, then a single handshake
        do_reset();
        req = 16'h0020; di = 16'h0020; out_ready = 1'b0;
        cycle();
        chk("s3_sel", 32'(sel), 32'd5);
        chk("s3_y", 32'(y), 32'd1);
        for (int i = 0; i < 4; i++) begin
            di = (16'($urandom) & 16'hffdf) | ((i % 2 == 0) ? 16'h0000 : 16'h0020);
            cycle();
            chk("s3_stall_y", 32'(y), 32'd1);
            chk("s3_stall_sel", 32'(sel), 32'd5);
            chk("s3_stall_gnt", 32'(gnt), 32'h0020);
        end
        di = 16'h0000; out_ready = 1'b1;
        cycle();
        chk("s3_hs_y", 32'(y), 32'd0);
        out_ready = 1'b0; di = 16'hffff;
        cycle();
        chk("s3_after_one_hs_y", 32'(y), 32'd0);
        chk("s3_after_one_hs_sb", 32'(sb.size()), 32'd1);
        req = 16'h0000; out_ready = 1'b1;
        cycle();
        chk("s3_release", 32'(out_valid), 32'd0);

        // Scenario 4: req drops while sample pending; release sets ptr=4
        do_reset();
        req = 16'h0008; di = 16'h0008; out_ready = 1'b0;
        cycle();
        chk("s4_sel", 32'(sel), 32'd3);
        req = 16'h0000;
        for (int i = 0; i < 2; i++) begin
            cycle();
            chk("s4_hold_valid", 32'(out_valid), 32'd1);
            chk("s4_hold_gnt", 32'(gnt), 32'h0008);
        end
        out_ready = 1'b1;
        cycle();
        chk("s4_release", 32'(gnt), 32'h0);
        req = 16'h0018;
        cycle();
        chk("s4_ptr4_sel", 32'(sel), 32'd4);
        req = 16'h0000;
        cycle();

        // Scenario 5: reset pulse between edges during XFER
        req = 16'h0004; out_ready = 1'b0;
        cycle();
        chk("s5_busy", 32'(busy), 32'd1);
        do_reset();
        req = 16'h0100;
        cycle();
        chk("s5_sel", 32'(sel), 32'd8);
        chk("s5_gnt", 32'(gnt), 32'h0100);

        // Random traffic
        do_reset();
        max_wait = 0;
        for (int i = 0; i < 10000; i++) begin
            req = 16'($urandom) & 16'($urandom);
            di = 16'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        chk("max_wait_le15", 32'(max_wait <= 15), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
